// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//
// Receives a 6-bit serial frame (start 0, X1, X2, X3, parity P, stop 1)
// one bit per BitEn strobe. It publishes the data word, pulses for a good
// frame, a parity error and a framing error, and keeps a saturating count
// of the error pulses.
//
// Ports:
//   Clock    - single clock, rising edge
//   Resetn   - asynchronous active-low reset
//   SerIn    - serial line, idles high
//   BitEn    - bit strobe; SerIn is sampled only when high
//   ClrCnt   - synchronous clear of ErrCount (beats a coincident error)
//   Q        - last good data word, Q[2]=X1, Q[1]=X2, Q[0]=X3
//   Valid    - one-cycle pulse: frame received with a good stop bit
//   ParErr   - one-cycle pulse alongside Valid when X1^X2^X3^P = 1
//   FrameErr - one-cycle pulse: stop bit sampled as 0
//   Busy     - high whenever the receiver is not idle
//   ErrCount - saturating count of ParErr + FrameErr pulses
module parity_frame_checker #(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             SerIn,
  input  logic             BitEn,
  input  logic             ClrCnt,
  output logic [2:0]       Q,
  output logic             Valid,
  output logic             ParErr,
  output logic             FrameErr,
  output logic             Busy,
  output logic [CNT_W-1:0] ErrCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t     state, next_state;
  logic [1:0] bit_idx, next_bit_idx;
  logic [2:0] shift_reg, next_shift_reg;
  logic       par_bit, next_par_bit;
  logic [2:0] next_q;
  logic       next_valid, next_par_err, next_frame_err;

  // Frame state, data and the result pulses are all registered together.
  // The pulse registers take their default of 0 every cycle, so they stay
  // high for exactly one clock after the stop-bit sample.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      bit_idx   <= 2'd0;
      shift_reg <= 3'b000;
      par_bit   <= 1'b0;
      Q         <= 3'b000;
      Valid     <= 1'b0;
      ParErr    <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      state     <= next_state;
      bit_idx   <= next_bit_idx;
      shift_reg <= next_shift_reg;
      par_bit   <= next_par_bit;
      Q         <= next_q;
      Valid     <= next_valid;
      ParErr    <= next_par_err;
      FrameErr  <= next_frame_err;
    end
  end

  // Next-state logic. Everything holds unless BitEn is high, which makes
  // arbitrary gaps between strobes harmless. Data shifts in MSB-first, so
  // the first data bit ends up in shift_reg[2] (X1). The STOP state always
  // returns to IDLE, so the very next strobe can be a new start bit.
  always_comb begin
    next_state     = state;
    next_bit_idx   = bit_idx;
    next_shift_reg = shift_reg;
    next_par_bit   = par_bit;
    next_q         = Q;
    next_valid     = 1'b0;
    next_par_err   = 1'b0;
    next_frame_err = 1'b0;

    if (BitEn) begin
      case (state)
        IDLE: begin
          if (!SerIn) begin
            next_state   = DATA;
            next_bit_idx = 2'd0;
          end
        end
        DATA: begin
          next_shift_reg = {shift_reg[1:0], SerIn};
          if (bit_idx == 2'd2) begin
            next_state   = PAR;
            next_bit_idx = 2'd0;
          end else begin
            next_bit_idx = bit_idx + 2'd1;
          end
        end
        PAR: begin
          next_par_bit = SerIn;
          next_state   = STOP;
        end
        STOP: begin
          next_state = IDLE;
          if (SerIn) begin
            next_q       = shift_reg;
            next_valid   = 1'b1;
            next_par_err = ^{shift_reg, par_bit};
          end else begin
            next_frame_err = 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  assign Busy = (state != IDLE);

  // The counter advances during the cycle an error pulse is visible. A clear
  // in that same cycle takes priority and the event is dropped. The counter
  // sticks at all-ones rather than wrapping.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ErrCount <= '0;
    end else if (ClrCnt) begin
      ErrCount <= '0;
    end else if ((ParErr || FrameErr) && (ErrCount != {CNT_W{1'b1}})) begin
      ErrCount <= ErrCount + 1'b1;
    end
  end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the error counter.
REQ-002 SHALL have port Clock  input  1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Resetn  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port SerIn  input  1: serial line; idles high.
REQ-005 SHALL have port BitEn  input  1: bit strobe; SerIn sampled only at edges where BitEn=1.
REQ-006 SHALL have port ClrCnt  input  1: synchronous clear of ErrCount.
REQ-007 SHALL have port Q  output  3: last good data word; Q[2]=X1, Q[1]=X2, Q[0]=X3.
REQ-008 SHALL have port Valid  output  1: one-cycle pulse, frame received with good stop bit.
REQ-009 SHALL have port ParErr  output  1: one-cycle pulse, coincident with Valid, parity mismatch.
REQ-010 SHALL have port FrameErr  output  1: one-cycle pulse, stop bit sampled as 0.
REQ-011 SHALL have port Busy  output  1: high in every state except IDLE.
REQ-012 SHALL have port ErrCount  output  CNT_W: saturating count of ParErr plus FrameErr events.

Function
REQ-013 Frame SHALL be, in order: start bit (0), X1, X2, X3, parity P, stop bit (1); one bit per BitEn sample.
REQ-014 P SHALL be the 3-input XOR produced by the team's existing generator (F=1 for X1X2X3 in {001,010,100,111}); a frame is good-parity iff X1^X2^X3^P = 0.
REQ-015 FSM states SHALL be IDLE, DATA, PAR, STOP, plus a 2-bit bit index used in DATA.
REQ-016 IDLE: BitEn=1 and SerIn=0 -> DATA with index 0; BitEn=1 and SerIn=1 -> stay IDLE.
REQ-017 DATA: each BitEn=1 shifts SerIn into a 3-bit shift register (first bit becomes X1); after the third bit -> PAR.
REQ-018 PAR: BitEn=1 captures P -> STOP.
REQ-019 STOP, BitEn=1, SerIn=1: load Q with the shift register, assert Valid, set ParErr = X1^X2^X3^P; -> IDLE.
REQ-020 STOP, BitEn=1, SerIn=0: assert FrameErr, Valid=0, ParErr=0, Q unchanged; -> IDLE.
REQ-021 Valid, ParErr, FrameErr SHALL be registered, high for exactly the one clock following the stop-bit sampling edge, low otherwise.
REQ-022 With BitEn=0 all state, index, and shift register SHALL hold; gaps of any length between strobes SHALL be tolerated.
REQ-023 ErrCount SHALL increment by 1 in the cycle ParErr or FrameErr is asserted, saturating at 2^CNT_W-1 (no wrap).
REQ-024 ClrCnt=1 SHALL set ErrCount to 0 at the next edge; ClrCnt and a simultaneous error event -> clear wins, event is lost.
REQ-025 A new start bit SHALL be accepted at the BitEn sample immediately following the stop bit (back-to-back frames, no idle bit required).

Reset
REQ-026 Resetn=0 SHALL immediately force state IDLE, index 0, shift register 000, P 0, Q=000, Valid=0, ParErr=0, FrameErr=0, Busy=0, ErrCount=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; no pulse is produced for it after release.
REQ-028 After Resetn rises, the first BitEn with SerIn=0 SHALL be treated as a start bit.

Verification
REQ-029 Frame 0,1,0,1,0,1 (X=101, P=0) -> Q=101, Valid=1 for one cycle, ParErr=0, ErrCount=0.
REQ-030 Frame 0,1,1,1,1,1 then frame 0,1,1,0,1,1 back-to-back -> first: Q=111, ParErr=0; second: Q=110, Valid=1, ParErr=1, ErrCount=1.
REQ-031 Frame 0,0,1,1,0,0 (bad stop) -> FrameErr=1, Valid=0, Q retains prior value, ErrCount increments.
REQ-032 Frame 0,1,0,0,1,1 with 0-5 idle cycles of BitEn=0 between every bit -> Q=100, Valid=1, ParErr=0, single pulse.
REQ-033 Resetn pulsed low after X1 of a frame, then good frame X=011, P=0 -> only one Valid pulse, Q=011, ErrCount=0.
REQ-034 CNT_W=2: five parity-error frames -> ErrCount 1,2,3,3,3; then ClrCnt=1 coincident with a sixth error pulse -> ErrCount=0.
